// File: rtl/cdc_handshake_tx.sv
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Source side of a four-phase req/ack CDC handshake. The optional
//            watchdog is built only when CDC_HS_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_tx #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_a1;
    logic             r_a2;
    logic             r_a3;
    logic             w_ack_s;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_done;
    logic             w_tmo;

    generate
        if (TIMEOUT_CYCLES < 8) begin : g_bad_timeout
            $error("cdc_handshake_tx: TIMEOUT_CYCLES must be at least 8");
        end
    endgenerate

    // xfer_ack is asynchronous to clk; only the third stage is trusted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a1 <= 1'b0;
            r_a2 <= 1'b0;
            r_a3 <= 1'b0;
        end else begin
            r_a1 <= xfer_ack;
            r_a2 <= r_a1;
            r_a3 <= r_a2;
        end
    end

    assign w_ack_s = r_a3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s || w_tmo) begin
                        r_req   <= 1'b0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A watchdog exit abandons the transfer, so no done pulse.
                    if (!w_ack_s) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_tmo) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int             CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  C_TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_leave;

    // Fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign w_tmo = (r_cnt == C_TMO_LAST);

    always_comb begin
        w_leave = 1'b1;
        case (r_state)
            ST_REQ:     w_leave = w_ack_s | w_tmo;
            ST_RELEASE: w_leave = ~w_ack_s | w_tmo;
            default:    w_leave = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo && (((r_state == ST_REQ) && !w_ack_s) ||
                               ((r_state == ST_RELEASE) && w_ack_s));
            r_cnt <= w_leave ? '0 : r_cnt + CW'(1);
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign xfer_req  = r_req;
    assign xfer_data = r_data;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Randomized self-checking bench for cdc_handshake_tx against a
//            cycle-level reference of the handshake timing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_handshake_tx;

    localparam int W   = 32;
    localparam int TMO = 16;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         xfer_ack = 1'b0;
    logic         in_ready;
    logic         xfer_req;
    logic [W-1:0] xfer_data;
    logic         done;
    logic         busy;
    logic         err;

    cdc_handshake_tx #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .xfer_req  (xfer_req),
        .xfer_data (xfer_data),
        .xfer_ack  (xfer_ack),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: phase 0 = idle, 1 = request outstanding, 2 = waiting ack fall.
    int           m_phase = 0;
    logic [W-1:0] m_data  = '0;
    logic         m_req   = 1'b0;
    logic         m_done  = 1'b0;
    logic         m_err   = 1'b0;
    int           m_edge  = 0;
    int           m_enter = 0;
    logic         ackq[$];

    int resp_en   = 0;
    int resp_rand = 0;
    int resp_dly  = 2;
    int resp_cnt  = 0;
    int done_seen = 0;
    int err_seen  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_req   = 1'b0;
        m_data  = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        ackq.delete();
    endtask

    // The FSM acts on the ack level sampled three edges earlier.
    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic a, input logic rn);
        logic seen;
        m_edge++;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rn) begin
            model_reset();
            return;
        end
        seen = (ackq.size() >= 3) ? ackq[ackq.size()-3] : 1'b0;
        ackq.push_back(a);
        if (ackq.size() > 3) void'(ackq.pop_front());
        case (m_phase)
            0: if (v) begin
                m_data = d; m_req = 1'b1; m_phase = 1; m_enter = m_edge;
            end
            1: if (seen) begin
                m_req = 1'b0; m_phase = 2; m_enter = m_edge;
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (m_edge - m_enter == TMO) begin
                m_req = 1'b0; m_phase = 2; m_err = 1'b1; m_enter = m_edge;
            end
`endif
            default: if (!seen) begin
                m_phase = 0; m_done = 1'b1;
            end
`ifdef CDC_HS_TIMEOUT_EN
            else if (m_edge - m_enter == TMO) begin
                m_phase = 0; m_err = 1'b1;
            end
`endif
        endcase
    endtask

    task automatic step();
        logic         v, a, rn;
        logic [W-1:0] d;
        @(posedge clk);
        v = in_valid; d = in_data; a = xfer_ack; rn = reset_n;
        #1;
        model_edge(v, d, a, rn);
        chk("in_ready",  in_ready,  m_phase == 0);
        chk("busy",      busy,      m_phase != 0);
        chk("xfer_req",  xfer_req,  m_req);
        chk("xfer_data", xfer_data, m_data);
        chk("done",      done,      m_done);
        chk("err",       err,       m_err);
        done_seen += int'(done);
        err_seen  += int'(err);
        // Destination responder: follows req after resp_dly observed cycles.
        if (resp_en != 0) begin
            if (xfer_req != xfer_ack) begin
                if (resp_cnt >= resp_dly) begin
                    xfer_ack = xfer_req;
                    resp_cnt = 0;
                    if (resp_rand != 0) resp_dly = $urandom_range(0, 4);
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    endtask

    initial begin
        logic rdy;
        int   guard;

        reset_n  = 1'b0;
        xfer_ack = 1'b1;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (8) step();
        chk("idle_after_reset_ack_high", busy, 1'b0);
        xfer_ack = 1'b0;
        repeat (4) step();

        resp_en = 1; resp_rand = 0; resp_dly = 2; resp_cnt = 0;
        done_seen = 0;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        repeat (30) step();
        chk("deadbeef_done_count", done_seen, 1);
        chk("deadbeef_data_held", xfer_data, 32'hDEADBEEF);

        done_seen = 0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = W'(k);
            guard = 0;
            do begin
                rdy = in_ready;
                step();
                guard++;
            end while (!rdy && guard < 60);
            chk("b2b_accept_in_time", guard < 60, 1'b1);
        end
        in_valid = 1'b0;
        repeat (30) step();
        chk("b2b_done_count", done_seen, 4);

        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_req_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_req", xfer_req, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        model_reset();
        done_seen = 0; err_seen = 0;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (12) step();
        chk("reset_no_done", done_seen, 0);
        chk("reset_no_err", err_seen, 0);
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
        repeat (30) step();
        chk("post_reset_done", done_seen, 1);

        resp_en = 0; xfer_ack = 1'b0;
        done_seen = 0; err_seen = 0;
        in_valid = 1'b1; in_data = $urandom;
        step();
        in_valid = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        repeat (40) step();
        chk("timeout_err_count", err_seen, 1);
        chk("timeout_done_count", done_seen, 1);
`else
        repeat (5000) step();
        chk("stall_busy", busy, 1'b1);
        chk("stall_req", xfer_req, 1'b1);
        chk("stall_err_count", err_seen, 0);
        reset_n = 1'b0;
        model_reset();
        repeat (2) step();
        reset_n = 1'b1;
        step();
`endif

        resp_en = 1; resp_rand = 1; resp_cnt = 0; resp_dly = 1;
        done_seen = 0;
        repeat (800) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            step();
        end
        in_valid = 1'b0;
        repeat (40) step();
        chk("random_some_done", done_seen > 20, 1'b1);
        chk("random_final_idle", in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
